ycbcr2rgb: RTL and testbench

YCBCR2RGB -- requirements
Module: ycbcr2rgb

---
 rtl/ycbcr2rgb_if.sv | 29 ++
 rtl/ycbcr2rgb.sv | 113 +++++++++++
 tb/tb_ycbcr2rgb.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr2rgb_if.sv
// Pixel stream bundle for the YCbCr to RGB converter.
// Input beats arrive on r*, converted beats leave on t*.
interface ycbcr2rgb_if #(
  parameter int pix_per_clock = 1,
  parameter int data_width = 8
);
  localparam int W = 3 * data_width * pix_per_clock;

  logic [W-1:0] rdata;
  logic         rvalid;
  logic         rready;
  logic         rlast;
  logic         ruser;
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         tuser;

  modport master (
    output rdata, rvalid, rlast, ruser, tready,
    input  rready, tdata, tvalid, tlast, tuser
  );

  modport slave (
    input  rdata, rvalid, rlast, ruser, tready,
    output rready, tdata, tvalid, tlast, tuser
  );
endinterface

// File: rtl/ycbcr2rgb.sv
// BT.709 limited-range YCbCr to RGB, three-stage pipeline
// with one global advance enable shared by all stages.
module ycbcr2rgb #(
  parameter int pix_per_clock = 1,
  parameter int data_width = 8
) (
  input logic        clk_in,
  input logic        reset_n,
  ycbcr2rgb_if.slave bus
);
  localparam int DW  = data_width;
  localparam int PPC = pix_per_clock;
  localparam int OW  = DW + 2;
  localparam int SW  = DW + 13;

  localparam logic signed [OW-1:0] Y_OFF = OW'(16 << (DW - 8));
  localparam logic signed [OW-1:0] C_OFF = OW'(1 << (DW - 1));
  localparam logic signed [SW-1:0] MAXV  = SW'((1 << DW) - 1);
  localparam logic signed [SW-1:0] RND   = SW'(128);
  localparam logic signed [SW-1:0] K_Y   = SW'(298);
  localparam logic signed [SW-1:0] K_RV  = SW'(459);
  localparam logic signed [SW-1:0] K_GU  = SW'(55);
  localparam logic signed [SW-1:0] K_GV  = SW'(136);
  localparam logic signed [SW-1:0] K_BU  = SW'(541);

  function automatic logic [DW-1:0] clamp(
    input logic signed [SW-1:0] s
  );
    logic signed [SW-1:0] sh;
    sh = s >>> 8;
    if (sh[SW-1]) return '0;
    if (sh > MAXV) return '1;
    return sh[DW-1:0];
  endfunction

  logic ce;
  logic v1, l1, u1;
  logic v2, l2, u2;
  logic v3, l3, u3;
  logic [PPC-1:0][3*DW-1:0] rgb;

  assign ce         = bus.tready | ~v3;
  assign bus.rready = ce;
  assign bus.tvalid = v3;
  assign bus.tlast  = l3;
  assign bus.tuser  = u3;
  assign bus.tdata  = rgb;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      u1 <= 1'b0;
      v2 <= 1'b0;
      l2 <= 1'b0;
      u2 <= 1'b0;
      v3 <= 1'b0;
      l3 <= 1'b0;
      u3 <= 1'b0;
    end else if (ce) begin
      v1 <= bus.rvalid;
      l1 <= bus.rvalid & bus.rlast;
      u1 <= bus.rvalid & bus.ruser;
      v2 <= v1;
      l2 <= l1;
      u2 <= u1;
      v3 <= v2;
      l3 <= l2;
      u3 <= u2;
    end
  end

  for (genvar p = 0; p < PPC; p++) begin : g_pix
    logic [DW-1:0]        y, cb, cr;
    logic signed [OW-1:0] yo, cbo, cro;
    logic signed [SW-1:0] ry, rv, gu, gv, bu;
    logic signed [SW-1:0] rs, gs, bs;
    logic [3*DW-1:0]      px;

    assign y   = bus.rdata[3*DW*p +: DW];
    assign cb  = bus.rdata[3*DW*p+DW +: DW];
    assign cr  = bus.rdata[3*DW*p+2*DW +: DW];
    assign yo  = $signed({2'b00, y}) - Y_OFF;
    assign cbo = $signed({2'b00, cb}) - C_OFF;
    assign cro = $signed({2'b00, cr}) - C_OFF;

    always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
        ry <= '0;
        rv <= '0;
        gu <= '0;
        gv <= '0;
        bu <= '0;
        rs <= '0;
        gs <= '0;
        bs <= '0;
        px <= '0;
      end else if (ce) begin
        ry <= SW'(yo) * K_Y;
        rv <= SW'(cro) * K_RV;
        gu <= SW'(cbo) * K_GU;
        gv <= SW'(cro) * K_GV;
        bu <= SW'(cbo) * K_BU;
        rs <= ry + rv + RND;
        gs <= ry - gu - gv + RND;
        bs <= ry + bu + RND;
        px <= {clamp(rs), clamp(gs), clamp(bs)};
      end
    end

    assign rgb[p] = px;
  end
endmodule

// File: tb/tb_ycbcr2rgb.sv
// Scoreboard bench for ycbcr2rgb: one-pixel and two-pixel
// instances, directed corners, stall, random flow and reset.
module tb_ycbcr2rgb;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ycbcr2rgb_if #(.pix_per_clock(1), .data_width(8)) b1 ();
  ycbcr2rgb_if #(.pix_per_clock(2), .data_width(8)) b2 ();

  ycbcr2rgb #(.pix_per_clock(1), .data_width(8)) dut1 (
    .clk_in (clk),
    .reset_n(rst_n),
    .bus    (b1)
  );

  ycbcr2rgb #(.pix_per_clock(2), .data_width(8)) dut2 (
    .clk_in (clk),
    .reset_n(rst_n),
    .bus    (b2)
  );

  typedef struct {
    logic [47:0] din;
    logic [47:0] dexp;
    logic        last;
    logic        user;
    int          cyc;
  } beat_t;

  beat_t src1[$];
  beat_t exp1[$];
  beat_t src2[$];
  beat_t exp2[$];

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  bit acc1 = 0;
  bit acc2 = 0;
  bit lat_chk = 0;
  bit rnd_v = 0;
  bit rnd_t = 0;
  bit t_hold = 0;

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cl(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic logic [23:0] ref_px(input logic [23:0] px);
    int y, cb, cr, r, g, b;
    y  = int'(px[7:0]) - 16;
    cb = int'(px[15:8]) - 128;
    cr = int'(px[23:16]) - 128;
    r  = (298 * y + 459 * cr + 128) >>> 8;
    g  = (298 * y - 55 * cb - 136 * cr + 128) >>> 8;
    b  = (298 * y + 541 * cb + 128) >>> 8;
    return {cl(r), cl(g), cl(b)};
  endfunction

  task automatic push1(
    input logic [23:0] din,
    input logic [23:0] dexp,
    input logic last,
    input logic user
  );
    src1.push_back('{din: 48'(din), dexp: 48'(dexp),
                     last: last, user: user, cyc: 0});
  endtask

  task automatic drain(input int budget);
    int n;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n = src1.size() + exp1.size() + src2.size() + exp2.size();
      if (n == 0) break;
    end
    n = src1.size() + exp1.size() + src2.size() + exp2.size();
    chk("drain", 64'(n), 64'd0);
  endtask

  // Driver: new values just after each rising edge
  initial begin
    b1.rvalid = 1'b0;
    b1.rdata  = '0;
    b1.rlast  = 1'b0;
    b1.ruser  = 1'b0;
    b1.tready = 1'b1;
    b2.rvalid = 1'b0;
    b2.rdata  = '0;
    b2.rlast  = 1'b0;
    b2.ruser  = 1'b0;
    b2.tready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (acc1) begin
        void'(src1.pop_front());
        acc1 = 0;
      end
      if (acc2) begin
        void'(src2.pop_front());
        acc2 = 0;
      end
      b1.rvalid = (src1.size() > 0) &&
                  (!rnd_v || $urandom_range(0, 1) == 1);
      if (src1.size() > 0) begin
        b1.rdata = src1[0].din[23:0];
        b1.rlast = src1[0].last;
        b1.ruser = src1[0].user;
      end
      b1.tready = t_hold ? 1'b0 :
                  (rnd_t ? ($urandom_range(0, 1) == 1) : 1'b1);
      b2.rvalid = (src2.size() > 0);
      if (src2.size() > 0) begin
        b2.rdata = src2[0].din;
        b2.rlast = src2[0].last;
        b2.ruser = src2[0].user;
      end
    end
  end

  // Monitor: handshakes are evaluated at the falling edge
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (b1.tvalid && b1.tready) begin
          if (exp1.size() == 0) begin
            chk("d1_extra_beat", 64'(exp1.size()), 64'd1);
          end else begin
            e = exp1.pop_front();
            chk("d1_tdata", 64'(b1.tdata), 64'(e.dexp[23:0]));
            chk("d1_tlast", 64'(b1.tlast), 64'(e.last));
            chk("d1_tuser", 64'(b1.tuser), 64'(e.user));
            if (lat_chk) chk("d1_latency", 64'(cyc - e.cyc), 64'd3);
          end
        end
        if (b1.rvalid && b1.rready && !acc1) begin
          e = src1[0];
          e.cyc = cyc;
          exp1.push_back(e);
          acc1 = 1;
        end
        if (b2.tvalid && b2.tready) begin
          if (exp2.size() == 0) begin
            chk("d2_extra_beat", 64'(exp2.size()), 64'd1);
          end else begin
            e = exp2.pop_front();
            chk("d2_tdata", 64'(b2.tdata), 64'(e.dexp));
            chk("d2_tlast", 64'(b2.tlast), 64'(e.last));
            if (lat_chk) chk("d2_latency", 64'(cyc - e.cyc), 64'd3);
          end
        end
        if (b2.rvalid && b2.rready && !acc2) begin
          e = src2[0];
          e.cyc = cyc;
          exp2.push_back(e);
          acc2 = 1;
        end
      end
    end
  end

  initial begin
    logic [23:0] px, px0, px1, held;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tvalid", 64'(b1.tvalid), 64'd0);
    chk("rst_tdata", 64'(b1.tdata), 64'd0);
    chk("rst_tlast", 64'(b1.tlast), 64'd0);
    chk("rst_tuser", 64'(b1.tuser), 64'd0);
    chk("rst_rready", 64'(b1.rready), 64'd1);
    chk("rst_d2_tvalid", 64'(b2.tvalid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Corner pixels, input packed {Cr, Cb, Y}, output {R, G, B}
    lat_chk = 1;
    push1({8'd128, 8'd128, 8'd16}, 24'h000000, 1'b0, 1'b1);
    drain(50);
    push1({8'd128, 8'd128, 8'd235}, 24'hFFFFFF, 1'b1, 1'b0);
    drain(50);
    push1({8'd240, 8'd90, 8'd81}, {8'd255, 8'd24, 8'd0}, 1'b0, 1'b0);
    drain(50);
    push1({8'd0, 8'd0, 8'd0}, {8'd0, 8'd77, 8'd0}, 1'b0, 1'b0);
    drain(50);

    // Ramp with a 5-cycle downstream stall
    lat_chk = 0;
    for (int i = 0; i < 40; i++) begin
      px = {8'(200 - 4 * i), 8'(60 + 3 * i), 8'(16 + 5 * i)};
      push1(px, ref_px(px), (i % 8) == 7, i == 0);
    end
    repeat (12) @(posedge clk);
    t_hold = 1;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) held = b1.tdata;
      else chk("stall_tdata", 64'(b1.tdata), 64'(held));
      chk("stall_rready", 64'(b1.rready), 64'd0);
      chk("stall_tvalid", 64'(b1.tvalid), 64'd1);
    end
    @(posedge clk);
    t_hold = 0;
    drain(200);

    // Random flow on both sides
    rnd_v = 1;
    rnd_t = 1;
    for (int i = 0; i < 1000; i++) begin
      px = 24'($urandom_range(0, 24'hFFFFFF));
      push1(px, ref_px(px), (i % 64) == 63, i == 0);
    end
    drain(20000);
    rnd_v = 0;
    rnd_t = 0;

    // Reset with beats in flight
    for (int i = 0; i < 10; i++) begin
      px = {8'(100 + i), 8'(150 - i), 8'(50 + 10 * i)};
      push1(px, ref_px(px), 1'b0, 1'b0);
    end
    repeat (5) @(negedge clk);
    chk("pre_rst_tvalid", 64'(b1.tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_tvalid", 64'(b1.tvalid), 64'd0);
    chk("async_tdata", 64'(b1.tdata), 64'd0);
    chk("async_rready", 64'(b1.rready), 64'd1);
    src1.delete();
    exp1.delete();
    acc1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale", 64'(b1.tvalid), 64'd0);
    end
    lat_chk = 1;
    push1({8'd128, 8'd128, 8'd235}, 24'hFFFFFF, 1'b1, 1'b1);
    drain(50);

    // Two pixels per beat, slot order kept
    src2.push_back('{din: {8'd128, 8'd128, 8'd235, 8'd128, 8'd128, 8'd16},
                     dexp: {24'hFFFFFF, 24'h000000},
                     last: 1'b0, user: 1'b1, cyc: 0});
    src2.push_back('{din: {8'd0, 8'd0, 8'd0, 8'd240, 8'd90, 8'd81},
                     dexp: {8'd0, 8'd77, 8'd0, 8'd255, 8'd24, 8'd0},
                     last: 1'b0, user: 1'b0, cyc: 0});
    for (int i = 0; i < 4; i++) begin
      px0 = {8'(30 + 40 * i), 8'(200 - 30 * i), 8'(20 + 50 * i)};
      px1 = {8'(220 - 45 * i), 8'(40 + 35 * i), 8'(230 - 40 * i)};
      src2.push_back('{din: {px1, px0},
                       dexp: {ref_px(px1), ref_px(px0)},
                       last: i == 3, user: 1'b0, cyc: 0});
    end
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
